// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: frame FSM states, protocol prefixes and
// the movement keys that the sprite logic decodes from `keycode`.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
    localparam logic [7:0] KEY_NONE         = 8'h00;

    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_D = 8'h23;

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchroniser plus a FILTER_LEN-sample debounce for one PS/2 line,
// emitting a one-cycle strobe on each filtered 1->0 transition.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          meta;
    logic          sync;
    logic          filt;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            filt <= 1'b1;
            cnt  <= '0;
            fall <= 1'b0;
        end else begin
            meta <= line;
            sync <= meta;
            fall <= 1'b0;
            // Any sample agreeing with the filtered level restarts the run.
            if (sync == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                filt <= sync;
                cnt  <= '0;
                fall <= filt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: frames 11-bit packets, decodes E0/F0 prefixes and
// holds the make code of the most recently pressed key until it is released.
module ps2_keycode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] keycode,
    output logic       key_ext,
    output logic       key_strobe,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       frame_err
);
    import ps2_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic          fall;
    logic          dat_meta;
    logic          dat_sync;
    frame_state_e  state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] to_cnt;
    logic          byte_valid;
    logic          pend_ext;
    logic          pend_break;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk  (Clk),
        .rst_n(Reset_n),
        .line (PS2_CLK),
        .fall (fall)
    );

    // Data is stable around the clock's falling edge, so no debounce needed.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            dat_meta <= PS2_DAT;
            dat_sync <= dat_meta;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (state == IDLE || fall)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (fall && !dat_sync) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (fall) begin
                        shreg   <= {dat_sync, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                end
                PARITY: begin
                    if (fall) begin
                        par_bit <= dat_sync;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (fall) begin
                        if ((^shreg ^ par_bit) && dat_sync)
                            byte_valid <= 1'b1;
                        else
                            frame_err <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A fall in the same cycle wins over the timeout.
            if (state != IDLE && !fall && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_ext   <= 1'b0;
            pend_break <= 1'b0;
            key_strobe <= 1'b0;
            key_code   <= '0;
            key_break  <= 1'b0;
            keycode    <= KEY_NONE;
            key_ext    <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (frame_err) begin
                pend_ext   <= 1'b0;
                pend_break <= 1'b0;
            end else if (byte_valid) begin
                if (shreg == PS2_PREFIX_EXT) begin
                    pend_ext <= 1'b1;
                end else if (shreg == PS2_PREFIX_BREAK) begin
                    pend_break <= 1'b1;
                end else begin
                    key_strobe <= 1'b1;
                    key_code   <= shreg;
                    key_break  <= pend_break;
                    pend_ext   <= 1'b0;
                    pend_break <= 1'b0;
                    if (!pend_break) begin
                        keycode <= shreg;
                        key_ext <= pend_ext;
                    end else if (shreg == keycode && pend_ext == key_ext) begin
                        // Only the release of the held key clears it.
                        keycode <= KEY_NONE;
                        key_ext <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: drives PS/2 frames, a reference model
// queues expected events, and monitors pop and check them with exact latency.
`timescale 1ns/1ps
module tb_ps2_keycode_rx;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int HALF           = 30;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic [7:0] keycode;
    logic       key_ext;
    logic       key_strobe;
    logic [7:0] key_code;
    logic       key_break;
    logic       frame_err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] code;
        logic       brk;
        logic [7:0] held;
        logic       ext;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   err_q[$];

    logic [7:0] m_held = 8'h00;
    logic       m_ext  = 1'b0;
    logic       m_pext = 1'b0;
    logic       m_pbrk = 1'b0;

    ps2_keycode_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .keycode   (keycode),
        .key_ext   (key_ext),
        .key_strobe(key_strobe),
        .key_code  (key_code),
        .key_break (key_break),
        .frame_err (frame_err)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge Clk) begin
        exp_t e;
        int   at;
        if (Reset_n && key_strobe) begin
            chk("strobe_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("key_code",       key_code,  e.code);
                chk("key_break",      key_break, e.brk);
                chk("keycode",        keycode,   e.held);
                chk("key_ext",        key_ext,   e.ext);
                chk("strobe_latency", cyc,       e.at);
            end
        end
        if (Reset_n && frame_err) begin
            chk("err_expected", int'(err_q.size() > 0), 1);
            if (err_q.size() > 0) begin
                at = err_q.pop_front();
                chk("err_latency", cyc, at);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic clk_bit(input logic b, output int t);
        PS2_DAT = b;
        idle(HALF);
        PS2_CLK = 1'b0;
        t = cyc;
        idle(HALF);
        PS2_CLK = 1'b1;
    endtask

    task automatic model(input logic [7:0] b, input logic bad, input int t);
        if (bad) begin
            err_q.push_back(t + FILTER_LEN + 3);
            m_pext = 1'b0;
            m_pbrk = 1'b0;
        end else if (b == 8'hE0) begin
            m_pext = 1'b1;
        end else if (b == 8'hF0) begin
            m_pbrk = 1'b1;
        end else begin
            if (!m_pbrk) begin
                m_held = b;
                m_ext  = m_pext;
            end else if (b == m_held && m_pext == m_ext) begin
                m_held = 8'h00;
                m_ext  = 1'b0;
            end
            sb.push_back('{b, m_pbrk, m_held, m_ext, t + FILTER_LEN + 4});
            m_pext = 1'b0;
            m_pbrk = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic bad);
        int   t;
        logic par;
        par = (~^b) ^ bad;
        clk_bit(1'b0, t);
        for (int i = 0; i < 8; i++) clk_bit(b[i], t);
        clk_bit(par, t);
        PS2_DAT = 1'b1;
        idle(HALF);
        PS2_CLK = 1'b0;
        t = cyc;
        model(b, bad, t);
        idle(HALF);
        PS2_CLK = 1'b1;
        idle(2 * HALF);
    endtask

    task automatic check_held(input string tag);
        chk({tag, "_keycode"}, keycode, m_held);
        chk({tag, "_key_ext"}, key_ext, m_ext);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_keycode"},    keycode,    0);
        chk({tag, "_key_ext"},    key_ext,    0);
        chk({tag, "_key_strobe"}, key_strobe, 0);
        chk({tag, "_key_code"},   key_code,   0);
        chk({tag, "_key_break"},  key_break,  0);
        chk({tag, "_frame_err"},  frame_err,  0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        idle(4);
        check_zero("reset");
        Reset_n = 1'b1;
        idle(20);

        // Make, then break of the held key
        send(8'h1D, 1'b0);
        check_held("make_1d");
        send(8'hF0, 1'b0);
        send(8'h1D, 1'b0);
        check_held("break_1d");

        // Break of a different key leaves the held key alone
        send(8'h1D, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h1C, 1'b0);
        check_held("other_break");
        chk("other_break_held", keycode, 8'h1D);
        send(8'hE0, 1'b0);
        send(8'h75, 1'b0);
        check_held("ext_make");
        chk("ext_make_flag", key_ext, 1);
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h75, 1'b0);
        check_held("ext_break");
        chk("ext_break_held", keycode, 8'h00);

        // Typematic repeat re-strobes without changing the held key
        send(8'h23, 1'b0);
        send(8'h23, 1'b0);
        check_held("typematic");

        // Bad parity: error pulse, no strobe, then recovery
        send(8'h1D, 1'b1);
        check_held("parity_err");
        send(8'h23, 1'b0);
        check_held("after_parity");

        // Partial frame then silence
        clk_bit(1'b0, t);
        for (int i = 0; i < 4; i++) clk_bit(i[0], t);
        PS2_DAT = 1'b1;
        err_q.push_back(t + FILTER_LEN + 3 + TIMEOUT_CYCLES);
        idle(TIMEOUT_CYCLES + 100);
        chk("timeout_err_seen", err_q.size(), 0);
        send(8'h1C, 1'b0);
        check_held("after_timeout");

        // Short low glitch with data low must not start a frame
        PS2_DAT = 1'b0;
        PS2_CLK = 1'b0;
        idle(3);
        PS2_CLK = 1'b1;
        idle(HALF);
        PS2_DAT = 1'b1;
        idle(HALF);
        send(8'hF0, 1'b0);
        send(8'h1C, 1'b0);
        check_held("after_glitch");
        send(8'h1D, 1'b0);
        check_held("pre_reset");

        // Reset mid-frame discards everything
        clk_bit(1'b0, t);
        clk_bit(1'b1, t);
        clk_bit(1'b0, t);
        Reset_n = 1'b0;
        #1;
        check_zero("mid_reset");
        m_held = 8'h00;
        m_ext  = 1'b0;
        m_pext = 1'b0;
        m_pbrk = 1'b0;
        PS2_DAT = 1'b1;
        PS2_CLK = 1'b1;
        idle(10);
        Reset_n = 1'b1;
        idle(20);
        send(8'h1B, 1'b0);
        check_held("after_reset");
        chk("after_reset_code", keycode, 8'h1B);

        idle(40);
        chk("sb_drained",  sb.size(),    0);
        chk("err_drained", err_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
